// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the data-memory arbiter slice.
//   PORT_C / PORT_H : port identifiers used to tag outstanding read responses
//   DEF_DW          : default data width
//   DEF_STRB_W      : default byte-enable width (DEF_DW / 8)
//   strb_width()    : byte-enable width for an arbitrary data width
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_H = 1'b1;

    localparam int DEF_DW     = 32;
    localparam int DEF_STRB_W = DEF_DW / 8;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// ---------------------------------------------------------------------------
// arb_starve_cnt
// Saturating count of consecutive cycles the host has been held off.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   h_valid    : host request pending
//   h_grant    : host granted this cycle
//   cnt        : current wait count (8 bits)
//   starved    : count has reached MAX_WAIT
// ---------------------------------------------------------------------------
module arb_starve_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_valid,
    input  logic       h_grant,
    output logic [7:0] cnt,
    output logic       starved
);

    localparam logic [7:0] MAX_C = 8'(MAX_WAIT);

    logic [7:0] cnt_r;

    // Wait counter: cleared whenever the host is served or withdraws,
    // otherwise counts blocked cycles and sticks at MAX_C.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (h_grant || !h_valid) begin
            cnt_r <= 8'd0;
        end else if (cnt_r < MAX_C) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt     = cnt_r;
    assign starved = (cnt_r == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the core (C) and a host/debug
// loader (H). Core has fixed priority unless the host has been held off for
// HOST_MAX_WAIT consecutive cycles, in which case the host wins once.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   c_* / h_*                  : valid/ready request channel, write flag,
//                                address, store data, byte enables, and
//                                read-response valid/data per requester
//   mem_en/we/addr/wdata/wstrb : memory strobe and payload of granted port
//   mem_rdata                  : memory read data (one cycle after strobe)
//   host_starved               : host wait counter is at HOST_MAX_WAIT
// ---------------------------------------------------------------------------
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            c_valid,
    output logic            c_ready,
    input  logic            c_we,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    input  logic [DW/8-1:0] c_wstrb,
    output logic            c_rvalid,
    output logic [DW-1:0]   c_rdata,
    input  logic            h_valid,
    output logic            h_ready,
    input  logic            h_we,
    input  logic [AW-1:0]   h_addr,
    input  logic [DW-1:0]   h_wdata,
    input  logic [DW/8-1:0] h_wstrb,
    output logic            h_rvalid,
    output logic [DW-1:0]   h_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata,
    output logic            host_starved
);

    localparam int SW = strb_width(DW);

    logic          c_grant_s;
    logic          h_grant_s;
    logic          starved_s;
    logic [7:0]    wait_cnt_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;
    logic [SW-1:0] mem_wstrb_s;
    logic          rd_pend_r;
    logic          rd_owner_r;

    arb_starve_cnt #(
        .MAX_WAIT (HOST_MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .h_valid (h_valid),
        .h_grant (h_grant_s),
        .cnt     (wait_cnt_s),
        .starved (starved_s)
    );

    // Grant decision: forced host grant beats core priority; nothing is
    // granted while reset is held so the memory sees no strobe.
    always_comb begin
        c_grant_s = 1'b0;
        h_grant_s = 1'b0;
        if (!rst_n) begin
            c_grant_s = 1'b0;
            h_grant_s = 1'b0;
        end else if (starved_s && h_valid) begin
            h_grant_s = 1'b1;
        end else if (c_valid) begin
            c_grant_s = 1'b1;
        end else if (h_valid) begin
            h_grant_s = 1'b1;
        end else begin
            c_grant_s = 1'b0;
            h_grant_s = 1'b0;
        end
    end

    // Memory payload mux: granted port's fields, zero when idle; byte
    // enables are suppressed on reads so the memory never sees stray strobes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        mem_wstrb_s = {SW{1'b0}};
        if (c_grant_s) begin
            mem_we_s    = c_we;
            mem_addr_s  = c_addr;
            mem_wdata_s = c_wdata;
            mem_wstrb_s = c_we ? c_wstrb : {SW{1'b0}};
        end else if (h_grant_s) begin
            mem_we_s    = h_we;
            mem_addr_s  = h_addr;
            mem_wdata_s = h_wdata;
            mem_wstrb_s = h_we ? h_wstrb : {SW{1'b0}};
        end else begin
            mem_we_s    = 1'b0;
            mem_addr_s  = {AW{1'b0}};
            mem_wdata_s = {DW{1'b0}};
            mem_wstrb_s = {SW{1'b0}};
        end
    end

    // Response tag: remember whether this cycle issued a read and for whom;
    // the owner only matters while rd_pend_r is set, so it holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= PORT_C;
        end else begin
            rd_pend_r <= (c_grant_s || h_grant_s) && !mem_we_s;
            if (c_grant_s || h_grant_s) begin
                rd_owner_r <= h_grant_s ? PORT_H : PORT_C;
            end else begin
                rd_owner_r <= rd_owner_r;
            end
        end
    end

    assign c_ready      = c_grant_s;
    assign h_ready      = h_grant_s;
    assign mem_en       = c_grant_s | h_grant_s;
    assign mem_we       = mem_we_s;
    assign mem_addr     = mem_addr_s;
    assign mem_wdata    = mem_wdata_s;
    assign mem_wstrb    = mem_wstrb_s;

    // Responses and status are masked while reset is asserted so a read in
    // flight at reset never surfaces.
    assign c_rvalid     = rst_n && rd_pend_r && (rd_owner_r == PORT_C);
    assign h_rvalid     = rst_n && rd_pend_r && (rd_owner_r == PORT_H);
    assign c_rdata      = c_rvalid ? mem_rdata : {DW{1'b0}};
    assign h_rdata      = h_rvalid ? mem_rdata : {DW{1'b0}};
    assign host_starved = rst_n && starved_s && (wait_cnt_s != 8'd0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives two arbiters (HOST_MAX_WAIT = 8 and = 1) from shared stimulus and
// compares every output each cycle with a behavioural model of the
// arbitration, starvation and read-response rules.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    typedef struct packed {
        logic          c_ready;
        logic          h_ready;
        logic          mem_en;
        logic          mem_we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic          c_rvalid;
        logic          h_rvalid;
        logic [DW-1:0] c_rdata;
        logic [DW-1:0] h_rdata;
        logic          starved;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          c_valid, c_we, h_valid, h_we;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata, mem_rdata;
    logic [SW-1:0] c_wstrb, h_wstrb;

    logic          a_c_ready, a_h_ready, a_c_rvalid, a_h_rvalid;
    logic [DW-1:0] a_c_rdata, a_h_rdata, a_mem_wdata;
    logic          a_mem_en, a_mem_we, a_starved;
    logic [AW-1:0] a_mem_addr;
    logic [SW-1:0] a_mem_wstrb;

    logic          b_c_ready, b_h_ready, b_c_rvalid, b_h_rvalid;
    logic [DW-1:0] b_c_rdata, b_h_rdata, b_mem_wdata;
    logic          b_mem_en, b_mem_we, b_starved;
    logic [AW-1:0] b_mem_addr;
    logic [SW-1:0] b_mem_wstrb;

    dmem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_ready(a_c_ready), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata),
        .h_valid(h_valid), .h_ready(a_h_ready), .h_we(h_we), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_rvalid(a_h_rvalid), .h_rdata(a_h_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(mem_rdata),
        .host_starved(a_starved)
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_ready(b_c_ready), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
        .h_valid(h_valid), .h_ready(b_h_ready), .h_we(h_we), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_rvalid(b_h_rvalid), .h_rdata(b_h_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(mem_rdata),
        .host_starved(b_starved)
    );

    int errors = 0;
    int checks = 0;

    // Reference state per instance: blocked-cycle count, outstanding read, its owner (1 = host)
    int maxw  [2] = '{8, 1};
    int wcnt  [2] = '{0, 0};
    bit pend  [2] = '{1'b0, 1'b0};
    bit owner [2] = '{1'b0, 1'b0};
    bit last_cr = 1'b0;
    bit last_hr = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which port the rules award this cycle: bit1 = host, bit0 = core
    function automatic logic [1:0] who_wins(input int i);
        if (!rst_n)                            return 2'b00;
        if (h_valid && (wcnt[i] == maxw[i]))   return 2'b10;
        if (c_valid)                           return 2'b01;
        if (h_valid)                           return 2'b10;
        return 2'b00;
    endfunction

    function automatic snap_t expected(input int i);
        snap_t e;
        logic [1:0] w;
        e = '0;
        if (!rst_n) return e;
        w = who_wins(i);
        if (w == 2'b01) begin
            e.c_ready = 1'b1; e.mem_en = 1'b1; e.mem_we = c_we;
            e.addr = c_addr; e.wdata = c_wdata; e.wstrb = c_we ? c_wstrb : 4'h0;
        end else if (w == 2'b10) begin
            e.h_ready = 1'b1; e.mem_en = 1'b1; e.mem_we = h_we;
            e.addr = h_addr; e.wdata = h_wdata; e.wstrb = h_we ? h_wstrb : 4'h0;
        end
        if (pend[i] && owner[i]) begin
            e.h_rvalid = 1'b1; e.h_rdata = mem_rdata;
        end else if (pend[i]) begin
            e.c_rvalid = 1'b1; e.c_rdata = mem_rdata;
        end
        e.starved = (wcnt[i] == maxw[i]);
        return e;
    endfunction

    function automatic snap_t observed(input int i);
        if (i == 0)
            return '{a_c_ready, a_h_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata,
                     a_mem_wstrb, a_c_rvalid, a_h_rvalid, a_c_rdata, a_h_rdata, a_starved};
        return '{b_c_ready, b_h_ready, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata,
                 b_mem_wstrb, b_c_rvalid, b_h_rvalid, b_c_rdata, b_h_rdata, b_starved};
    endfunction

    task automatic compare_all(input int i);
        snap_t o, e;
        string p;
        o = observed(i);
        e = expected(i);
        p = (i == 0) ? "w8" : "w1";
        check_eq({p, ".c_ready"},  64'(o.c_ready),  64'(e.c_ready));
        check_eq({p, ".h_ready"},  64'(o.h_ready),  64'(e.h_ready));
        check_eq({p, ".mem_en"},   64'(o.mem_en),   64'(e.mem_en));
        check_eq({p, ".mem_we"},   64'(o.mem_we),   64'(e.mem_we));
        check_eq({p, ".mem_addr"}, 64'(o.addr),     64'(e.addr));
        check_eq({p, ".mem_wdata"},64'(o.wdata),    64'(e.wdata));
        check_eq({p, ".mem_wstrb"},64'(o.wstrb),    64'(e.wstrb));
        check_eq({p, ".c_rvalid"}, 64'(o.c_rvalid), 64'(e.c_rvalid));
        check_eq({p, ".h_rvalid"}, 64'(o.h_rvalid), 64'(e.h_rvalid));
        check_eq({p, ".c_rdata"},  64'(o.c_rdata),  64'(e.c_rdata));
        check_eq({p, ".h_rdata"},  64'(o.h_rdata),  64'(e.h_rdata));
        check_eq({p, ".starved"},  64'(o.starved),  64'(e.starved));
    endtask

    // Inputs are already applied (just after a falling edge): check, advance model, move on
    task automatic run_cycle();
        logic [1:0] w;
        bit         granted_we;
        #1;
        for (int i = 0; i < 2; i++) compare_all(i);
        w = who_wins(0);
        last_cr = w[0];
        last_hr = w[1];
        for (int i = 0; i < 2; i++) begin
            w = who_wins(i);
            granted_we = w[1] ? h_we : c_we;
            if (!rst_n) begin
                wcnt[i] = 0; pend[i] = 1'b0; owner[i] = 1'b0;
            end else begin
                if (w[1] || !h_valid)        wcnt[i] = 0;
                else if (wcnt[i] < maxw[i])  wcnt[i] = wcnt[i] + 1;
                pend[i]  = (w != 2'b00) && !granted_we;
                owner[i] = w[1];
            end
        end
        @(negedge clk);
    endtask

    // Random requests that respect the hold-until-ready rule (host occasionally withdraws)
    task automatic gen(input int pc, input int ph);
        if (!(c_valid && !last_cr)) begin
            c_valid = ($urandom_range(99) < pc);
            c_we    = 1'($urandom_range(1));
            c_addr  = $urandom & 32'h0000_00FC;
            c_wdata = $urandom;
            c_wstrb = 4'($urandom_range(15));
        end
        if (!(h_valid && !last_hr && ($urandom_range(99) >= 3))) begin
            h_valid = ($urandom_range(99) < ph);
            h_we    = 1'($urandom_range(1));
            h_addr  = $urandom & 32'h0000_0FFC;
            h_wdata = $urandom;
            h_wstrb = 4'($urandom_range(15));
        end
        mem_rdata = $urandom;
        rst_n     = ($urandom_range(199) != 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n = 1'b0; c_valid = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0;
        h_valid = 1'b0; h_we = 1'b0; h_addr = 32'h0; h_wdata = 32'h0; h_wstrb = 4'h0;
        mem_rdata = 32'h0;
        @(negedge clk);
        run_cycle();
        run_cycle();
        rst_n = 1'b1;

        // Core-only read at 0x10, data returned next cycle
        c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wstrb = 4'hF;
        run_cycle();
        c_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        #1 check_eq("core_read_rdata", 64'(a_c_rdata), 64'h0000_0000_DEAD_BEEF);
        run_cycle();

        // Host write while core idle: strobes pass through, no response afterwards
        h_valid = 1'b1; h_we = 1'b1; h_addr = 32'h20; h_wdata = 32'h1234_5678; h_wstrb = 4'b0011;
        run_cycle();
        h_valid = 1'b0;
        run_cycle();

        // Both requesting from a clear counter: host should win on the 9th cycle
        c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h0;
        h_valid = 1'b1; h_we = 1'b0; h_addr = 32'h4;
        n = 99; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (a_h_ready === 1'b1) begin
                seen = 1'b1;
                n = k;
            end
            run_cycle();
        end
        check_eq("starve_grant_cycle", 64'(n), 64'd8);
        h_valid = 1'b0;
        run_cycle();

        // Reset landing on the cycle after a granted read
        c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h40;
        run_cycle();
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1; c_valid = 1'b0;
        #1 check_eq("post_reset_rvalid", 64'(a_c_rvalid), 64'd0);
        run_cycle();

        // Random traffic at light, medium and heavy load
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 600; k++) begin
                gen((p == 0) ? 30 : (p == 1) ? 70 : 95, (p == 0) ? 30 : (p == 1) ? 60 : 90);
                run_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
